// File: rtl/ram8_stack_ctrl_pkg.sv
// Shared encodings for the RAM8 LIFO controller: request opcodes and FSM states.
package ram8_stack_ctrl_pkg;

  typedef enum logic [1:0] {
    OpPush  = 2'b00,
    OpPop   = 2'b01,
    OpPeek  = 2'b10,
    OpClear = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StExec  = 2'b01,
    StScrub = 2'b10,
    StResp  = 2'b11
  } state_e;

endpackage

// File: rtl/ram8_stack_ctrl.sv
// LIFO controller in front of the 8x8 scratch RAM: one op in flight, IDLE -> EXEC/SCRUB -> RESP,
// owns the stack pointer and drives the single RAM port combinationally from the FSM state.
module ram8_stack_ctrl
  import ram8_stack_ctrl_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 3,
  parameter bit          SCRUB = 1'b1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [DW-1:0] req_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic [AW:0]   level,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do
);

  localparam logic [AW:0] SpFull = (AW+1)'(2**AW);
  localparam logic [AW:0] SpOne  = (AW+1)'(1);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [AW:0]   sp_q, sp_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic          full, empty;

  assign full  = (sp_q == SpFull);
  assign empty = (sp_q == '0);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sp_d       = sp_q;
    data_d     = data_q;
    idx_d      = idx_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_di     = '0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d       = op_e'(req_op);
          data_d     = req_data;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          idx_d      = '0;
          state_d    = (op_e'(req_op) == OpClear && SCRUB) ? StScrub : StExec;
        end
      end
      StExec: begin
        state_d = StResp;
        case (op_q)
          OpPush: begin
            if (full) begin
              rsp_err_d = 1'b1;
            end else begin
              ram_en   = 1'b1;
              ram_we   = 1'b1;
              ram_addr = sp_q[AW-1:0];
              ram_di   = data_q;
              sp_d     = sp_q + SpOne;
            end
          end
          OpPop, OpPeek: begin
            if (empty) begin
              rsp_err_d = 1'b1;
            end else begin
              // Do0 is combinational, so the read data is captured in this same cycle.
              ram_en     = 1'b1;
              ram_addr   = AW'(sp_q - SpOne);
              rsp_data_d = ram_do;
              if (op_q == OpPop) sp_d = sp_q - SpOne;
            end
          end
          default: sp_d = '0;
        endcase
      end
      StScrub: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = idx_q;
        idx_d    = idx_q + AW'(1);
        if (idx_q == '1) begin
          sp_d    = '0;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      op_q       <= OpPush;
      sp_q       <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sp_q       <= sp_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign level     = sp_q;

endmodule
